// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding-select encoding, the stage control bundle, and the load opcode for upstream decoders.
package hazard_pkg;

  localparam int SEL_RF       = 0;
  localparam int SEL_FWD_BASE = 1;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  // One bit per pipeline register, used for both the enables and the clears.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_ctl_t;

endpackage

// File: rtl/hazard_scoreboard_unit_fwd_sel_enc.sv
// Priority encoder that picks the youngest forwarding source writing the operand register.
// Purely combinational, zero latency, with no flow control of its own.
module fwd_sel_enc
  import hazard_pkg::*;
#(
  parameter int NFWD = 2,
  parameter int AW   = 5,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic [AW-1:0]      rs,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  output logic [SELW-1:0]    sel
);

  always_comb begin
    sel = SELW'(SEL_RF);
    // Walk from the oldest source to the youngest so that the youngest match is the one that sticks.
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (rs != '0 && fwd_we[k] && fwd_waddr[k*AW +: AW] == rs) begin
        sel = SELW'(k + SEL_FWD_BASE);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller: forwarding selects, load-use and scoreboard stalls, late-data bubbles, flush and memory freeze.
// Controls are combinational from the current inputs; scoreboard updates land on the next edge. HAZARD_PERF_EN adds the stall and flush counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NFWD = 2,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [AW-1:0]      id_rs1,
  input  logic [AW-1:0]      id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_rf_we,
  input  logic               id_is_long,
  input  logic [AW-1:0]      ex_rs1,
  input  logic [AW-1:0]      ex_rs2,
  input  logic [AW-1:0]      ex_rd,
  input  logic               ex_rf_we,
  input  logic               ex_is_load,
  input  logic               ex_is_long,
  input  logic               ex_bu_branch,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD-1:0]    fwd_ready,
  input  logic               long_done,
  input  logic [AW-1:0]      long_rd,
  input  logic               mem_busy,
  output logic               pc_enable,
  output logic               if_id_enable,
  output logic               id_ex_enable,
  output logic               ex_mem_enable,
  output logic               mem_wb_enable,
  output logic               if_id_rstn,
  output logic               id_ex_rstn,
  output logic               ex_mem_rstn,
  output logic               mem_wb_rstn,
  output logic [SELW-1:0]    ex_rs1_sel,
  output logic [SELW-1:0]    ex_rs2_sel,
  output logic [NREG-1:0]    sb_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_lu_stalls,
  output logic [31:0]        perf_sb_stalls,
  output logic [31:0]        perf_flushes
`endif
);

  logic [NREG-1:0] busy, busy_nxt;
  logic            long_busy;
  logic [SELW-1:0] sel1, sel2;
  logic            freeze, flush, late, lu, issue, sbh;
  logic            rs1_hit, rs2_hit, rd_hit;
  logic            stall_lu, stall_sb;
  stage_ctl_t      en, clr_n;

  fwd_sel_enc #(.NFWD(NFWD), .AW(AW), .SELW(SELW)) u_rs1_enc (
    .rs(ex_rs1), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .sel(sel1)
  );

  fwd_sel_enc #(.NFWD(NFWD), .AW(AW), .SELW(SELW)) u_rs2_enc (
    .rs(ex_rs2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .sel(sel2)
  );

  always_comb begin
    late = 1'b0;
    for (int k = 0; k < NFWD; k++) begin
      if ((sel1 == SELW'(k + SEL_FWD_BASE) || sel2 == SELW'(k + SEL_FWD_BASE)) && !fwd_ready[k]) begin
        late = 1'b1;
      end
    end
  end

  assign freeze = mem_busy;
  assign flush  = ex_bu_branch & ~freeze;
  assign lu     = ex_is_load & ex_rf_we & (ex_rd != '0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign issue  = ex_is_long & ex_rf_we & (ex_rd != '0) & ~freeze & ~late;

  // busy[0] is pinned low and issue never targets x0, so x0 reads and writes can never hit.
  assign rs1_hit = id_rs1_used & (busy[id_rs1] | (issue & (id_rs1 == ex_rd)));
  assign rs2_hit = id_rs2_used & (busy[id_rs2] | (issue & (id_rs2 == ex_rd)));
  assign rd_hit  = id_rf_we    & (busy[id_rd]  | (issue & (id_rd  == ex_rd)));
  assign sbh     = rs1_hit | rs2_hit | rd_hit | (id_is_long & (long_busy | issue));

  assign stall_lu = lu  & ~freeze & ~flush & ~late;
  assign stall_sb = sbh & ~freeze & ~flush & ~late;

  always_comb begin
    en    = '1;
    clr_n = '1;
    if (freeze) begin
      en = '0;
    end else begin
      if (flush) begin
        clr_n.if_id = 1'b0;
        clr_n.id_ex = 1'b0;
      end
      // A flush keeps fetch moving to the branch target; late only holds the EX side then.
      if (late) begin
        if (!flush) begin
          en.pc    = 1'b0;
          en.if_id = 1'b0;
        end
        en.id_ex     = 1'b0;
        clr_n.ex_mem = 1'b0;
      end else if (stall_lu || stall_sb) begin
        en.pc       = 1'b0;
        en.if_id    = 1'b0;
        clr_n.id_ex = 1'b0;
      end
    end
    clr_n.mem_wb = 1'b1;
    if (!rstn) begin
      en    = '1;
      clr_n = '1;
    end
  end

  assign pc_enable     = en.pc;
  assign if_id_enable  = en.if_id;
  assign id_ex_enable  = en.id_ex;
  assign ex_mem_enable = en.ex_mem;
  assign mem_wb_enable = en.mem_wb;
  assign if_id_rstn    = clr_n.if_id;
  assign id_ex_rstn    = clr_n.id_ex;
  assign ex_mem_rstn   = clr_n.ex_mem;
  assign mem_wb_rstn   = clr_n.mem_wb;
  assign ex_rs1_sel    = rstn ? sel1 : '0;
  assign ex_rs2_sel    = rstn ? sel2 : '0;
  assign sb_busy       = busy;

  // Set after clear so an issue and a writeback to the same register leave it busy.
  always_comb begin
    busy_nxt = busy;
    if (long_done) busy_nxt[long_rd] = 1'b0;
    if (issue)     busy_nxt[ex_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy      <= '0;
      long_busy <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      long_busy <= issue | (long_busy & ~long_done);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_lu_stalls <= '0;
      perf_sb_stalls <= '0;
      perf_flushes   <= '0;
    end else begin
      if (stall_lu) perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (stall_sb) perf_sb_stalls <= perf_sb_stalls + 32'd1;
      if (flush)    perf_flushes   <= perf_flushes + 32'd1;
    end
  end
`else
  // Counters are not built; stall_lu/stall_sb still qualify the stall controls above.
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed control words and scoreboard values.
module tb_hazard_scoreboard_unit;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NFWD = 2;
  localparam int SELW = 2;

  // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem, mem_wb clears}
  localparam logic [8:0] CTL_RUN     = 9'b11111_1111;
  localparam logic [8:0] CTL_FREEZE  = 9'b00000_1111;
  localparam logic [8:0] CTL_FLUSH   = 9'b11111_0011;
  localparam logic [8:0] CTL_LATE    = 9'b00011_1101;
  localparam logic [8:0] CTL_STALL   = 9'b00111_1011;
  localparam logic [8:0] CTL_FL_LATE = 9'b11011_0001;

  logic clk = 1'b0;
  logic rstn;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, long_rd;
  logic id_rs1_used, id_rs2_used, id_rf_we, id_is_long;
  logic ex_rf_we, ex_is_load, ex_is_long, ex_bu_branch, long_done, mem_busy;
  logic [NFWD-1:0] fwd_we, fwd_ready;
  logic [NFWD*AW-1:0] fwd_waddr;
  logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic if_id_rstn, id_ex_rstn, ex_mem_rstn, mem_wb_rstn;
  logic [SELW-1:0] ex_rs1_sel, ex_rs2_sel;
  logic [NREG-1:0] sb_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_sb_stalls, perf_flushes;
`endif
  logic [8:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NREG(NREG), .AW(AW), .NFWD(NFWD), .SELW(SELW)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_long(id_is_long),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_is_load(ex_is_load), .ex_is_long(ex_is_long), .ex_bu_branch(ex_bu_branch),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_ready(fwd_ready),
    .long_done(long_done), .long_rd(long_rd), .mem_busy(mem_busy),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_rstn(if_id_rstn), .id_ex_rstn(id_ex_rstn), .ex_mem_rstn(ex_mem_rstn),
    .mem_wb_rstn(mem_wb_rstn),
    .ex_rs1_sel(ex_rs1_sel), .ex_rs2_sel(ex_rs2_sel), .sb_busy(sb_busy)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_sb_stalls(perf_sb_stalls), .perf_flushes(perf_flushes)
`endif
  );

  assign ctl = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                if_id_rstn, id_ex_rstn, ex_mem_rstn, mem_wb_rstn};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rf_we = 0; id_is_long = 0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_rf_we = 0; ex_is_load = 0;
    ex_is_long = 0; ex_bu_branch = 0;
    fwd_we = '0; fwd_waddr = '0; fwd_ready = '1;
    long_done = 0; long_rd = '0; mem_busy = 0;
  endtask

  // Inputs change 2 time units after the rising edge and are checked 1 unit later.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    #3;
    check("rst_busy", sb_busy, 0);
    check("rst_ctl", ctl, CTL_RUN);
    check("rst_sel1", ex_rs1_sel, 0);
    rstn = 1'b1;
    next();

    // Forwarding priority
    fwd_we = 2'b11; fwd_waddr = {5'd5, 5'd5}; ex_rs1 = 5'd5; #1;
    check("fwd_young", ex_rs1_sel, 1);
    check("fwd_ctl", ctl, CTL_RUN);
    fwd_we = 2'b10; #1;
    check("fwd_old", ex_rs1_sel, 2);
    fwd_we = 2'b11; fwd_waddr = {5'd0, 5'd0}; ex_rs1 = 5'd0; #1;
    check("fwd_x0", ex_rs1_sel, 0);
    next();
    fwd_waddr = {5'd4, 5'd3}; ex_rs2 = 5'd4; #1;
    check("fwd_rs2", ex_rs2_sel, 2);

    // Late forwarded data
    next(); idle();
    fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd5}; ex_rs1 = 5'd5; fwd_ready = 2'b10; #1;
    check("late_ctl", ctl, CTL_LATE);
    fwd_ready = 2'b01; #1;
    check("late_other_src", ctl, CTL_RUN);

    // Load-use
    next(); idle();
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1; #1;
    check("lu_stall", ctl, CTL_STALL);
    id_rs2_used = 0; #1;
    check("lu_unused", ctl, CTL_RUN);

    // Long op to x9, ID reads x9
    next(); idle();
    ex_is_long = 1; ex_rf_we = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1; #1;
    check("iss_stall", ctl, CTL_STALL);
    check("iss_busy_pre", sb_busy, 0);
    next();
    ex_is_long = 0; ex_rf_we = 0; ex_rd = '0; #1;
    check("sb_busy9", sb_busy, 32'h200);
    check("sb_raw", ctl, CTL_STALL);
    id_rs1_used = 0; id_is_long = 1; #1;
    check("sb_long_busy", ctl, CTL_STALL);
    id_is_long = 0; id_rs1_used = 1;
    next();
    long_done = 1; long_rd = 5'd9; #1;
    check("done_cycle", ctl, CTL_STALL);
    next();
    long_done = 0; #1;
    check("done_busy", sb_busy, 0);
    check("done_release", ctl, CTL_RUN);

    // Same-cycle set and clear of x3, then WAW
    next(); idle();
    ex_is_long = 1; ex_rf_we = 1; ex_rd = 5'd3; long_done = 1; long_rd = 5'd3;
    next(); idle(); #1;
    check("set_wins", sb_busy, 32'h8);
    id_rd = 5'd3; id_rf_we = 1; #1;
    check("waw_stall", ctl, CTL_STALL);
    id_rf_we = 0; long_done = 1; long_rd = 5'd3;
    next(); idle(); #1;
    check("x3_clear", sb_busy, 0);

    // Freeze with branch, then flush overriding a load-use
    next(); idle();
    mem_busy = 1; ex_bu_branch = 1; ex_is_long = 1; ex_rf_we = 1; ex_rd = 5'd12; #1;
    check("freeze_ctl", ctl, CTL_FREEZE);
    next(); #1;
    check("frz_no_issue", sb_busy, 0);
    mem_busy = 0; ex_is_long = 0; ex_is_load = 1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_rs1_used = 1; #1;
    check("flush_ctl", ctl, CTL_FLUSH);

    // Flush with late data
    next(); idle();
    ex_bu_branch = 1; fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd5}; ex_rs1 = 5'd5; fwd_ready = 2'b10; #1;
    check("flush_late", ctl, CTL_FL_LATE);

    // long_done to x0 clears only long_busy; async reset clears scoreboard
    next(); idle();
    ex_is_long = 1; ex_rf_we = 1; ex_rd = 5'd9;
    next(); idle();
    id_is_long = 1; #1;
    check("lb_stall", ctl, CTL_STALL);
    long_done = 1; long_rd = 5'd0;
    next();
    long_done = 0; #1;
    check("lb_clear", ctl, CTL_RUN);
    check("lb_keep9", sb_busy, 32'h200);
    rstn = 1'b0; #1;
    check("async_rst", sb_busy, 0);
    check("async_ctl", ctl, CTL_RUN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Second-generation pipeline hazard controller for the 5-stage RV32I core. It adds three things on top of priority-encoded operand forwarding, load-use stalling and branch flushing:
- a per-register scoreboard for a multi-cycle (mul/div) unit;
- late-data stall support for multi-cycle memory;
- a global freeze while data memory is busy.

It sits beside the pipeline registers and drives all of their enables and synchronous clears.

Parameters:
NREG, 32, number of architectural registers; x0 is never tracked.
AW, $clog2(NREG), register address width.
NFWD, 2, number of forwarding sources; index 0 is the youngest (EX/MEM), NFWD-1 the oldest.
SELW, $clog2(NFWD+1), forwarding select width.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  AW  source registers of the instruction in ID
id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads rs1/rs2
id_rd  in  AW  destination register of the ID instruction
id_rf_we  in  1  the ID instruction writes id_rd
id_is_long  in  1  the ID instruction is a multi-cycle op
ex_rs1, ex_rs2  in  AW  source registers of the instruction in EX
ex_rd  in  AW  destination register of the EX instruction
ex_rf_we  in  1  the EX instruction writes ex_rd
ex_is_load  in  1  the EX instruction is a load
ex_is_long  in  1  the EX instruction is a multi-cycle op
ex_bu_branch  in  1  taken branch/jump resolved in EX
fwd_we  in  NFWD  write enable of each forwarding source
fwd_waddr  in  NFWD*AW  destination of each source; slice k is source k
fwd_ready  in  NFWD  data of source k is valid this cycle
long_done  in  1  multi-cycle unit writes back this cycle
long_rd  in  AW  destination of that writeback
mem_busy  in  1  data memory not ready
pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1  stage enables
if_id_rstn, id_ex_rstn, ex_mem_rstn, mem_wb_rstn  out  1  synchronous clears, active low
ex_rs1_sel, ex_rs2_sel  out  SELW  0 = register file, k+1 = forwarding source k
sb_busy  out  NREG  scoreboard state, bit 0 always 0

Behaviour:
- State:
  - busy[NREG-1:0], registered.
  - long_busy, a 1-bit flag: the multi-cycle unit holds one outstanding op.
  - Reset (asynchronous, rstn=0): busy=0, long_busy=0. Enables 1, all clears 1 (deasserted), selects 0.
- Forwarding select, per operand, combinational:
  - Choose the smallest k with fwd_we[k], fwd_waddr[k]!=0 and fwd_waddr[k]==ex_rsX.
  - If no k matches, select 0. An operand address of 0 always selects 0.
- Conditions, evaluated in priority order:
  - freeze = mem_busy.
  - flush = ex_bu_branch & !freeze.
  - late = the selected source k for either EX operand has fwd_ready[k]=0.
  - lu = ex_is_load & ex_rf_we & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - issue = ex_is_long & ex_rf_we & ex_rd!=0 & !freeze & !late.
  - sbh = (used rs, or id_rd when id_rf_we) hits busy[], or hits ex_rd while issue=1. This covers RAW and WAW. Additionally sbh is set when id_is_long & (long_busy | issue).
- Outputs:
  - freeze: all enables 0, all clears 1. A branch held in EX re-asserts after the freeze releases.
  - flush: if_id_rstn=0, id_ex_rstn=0, pc_enable=1. lu and sbh are ignored. late still applies to the EX-side registers.
  - late (no freeze): pc/if_id/id_ex enables 0, ex_mem_rstn=0 to insert a bubble.
  - lu or sbh (no freeze, no flush, no late): pc_enable=0, if_id_enable=0, id_ex_rstn=0.
  - mem_wb_rstn is always 1. Enables not otherwise named are 1.
- Scoreboard update, on the clock edge:
  - issue sets busy[ex_rd] and long_busy.
  - long_done clears busy[long_rd] and long_busy.
  - Same register set and cleared in the same cycle: set wins.
  - Clears take effect next cycle, so ID stalls during the long_done cycle (deliberately conservative).
  - long_done with long_rd=0 only clears long_busy.

Optional Feature:
HAZARD_PERF_EN adds three 32-bit wrapping counters, reset to 0, each with an output port:
- perf_lu_stalls: cycles with lu stalling.
- perf_sb_stalls: cycles with sbh stalling.
- perf_flushes: flush cycles.

Counters do not count while freeze is asserted. Without the macro the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - select encoding constants: SEL_RF=0, SEL_FWD_BASE=1;
  - the opcode constant OP_LOAD=7'b0000011 for decoders upstream.
- Sub-module fwd_sel_enc: parametrised priority encoder, instantiated once per EX operand.

Test Plan:
- fwd_we=2'b11, both fwd_waddr=5, ex_rs1=5 -> ex_rs1_sel=1 (youngest wins). Same case with fwd_we=2'b10 -> ex_rs1_sel=2. ex_rs1=0 -> 0.
- Load with ex_rd=7, id_rs2=7, id_rs2_used=1 -> one cycle pc_enable=0, if_id_enable=0, id_ex_rstn=0. Same case with id_rs2_used=0 -> no stall.
- Long op with ex_rd=9 issues, ID reads x9 -> stalls from that cycle through the long_done(long_rd=9) cycle; released the next cycle. sb_busy[9]=1 in between.
- issue to x3 and long_done for x3 in the same cycle -> sb_busy[3]=1 afterwards.
- mem_busy=1 together with ex_bu_branch=1 -> all enables 0, no clears. mem_busy drops -> if_id_rstn=0, id_ex_rstn=0.
- fwd_ready[0]=0 with source 0 selected -> pc/if_id/id_ex enables 0, ex_mem_rstn=0. Assert rstn=0 mid-scoreboard -> sb_busy=0 immediately, without waiting for a clock edge.
